// File: rtl/full_adder_1bit_pkg.sv
// Shared types and helpers for the toggle-encoded 1-bit full adder.
package full_adder_1bit_pkg;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
  } fa_pulse_t;

  function automatic logic fa_par3(input fa_pulse_t p);
    return p.a ^ p.b ^ p.cin;
  endfunction

  function automatic logic fa_maj3(input fa_pulse_t p);
    return (p.a & p.b) | (p.a & p.cin) | (p.b & p.cin);
  endfunction

endpackage

// File: rtl/full_adder_1bit_if.sv
// Pulse-line bundle for the toggle-encoded adder: operands in, sum/carry out.
interface full_adder_1bit_if;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic cout;

  modport master (output a, b, cin, input sum, cout);
  modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/full_adder_1bit_toggle.sv
// Toggle register clocked on rising edges, and also on falling edges when DUAL_EDGE=1.
module dual_edge_toggle #(
  parameter bit DUAL_EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q_p;
  logic r_q_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)    r_q_p <= 1'b0;
    else if (t) r_q_p <= ~r_q_p;
  end

  generate
    if (DUAL_EDGE) begin : g_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst)    r_q_n <= 1'b0;
        else if (t) r_q_n <= ~r_q_n;
      end
    end else begin : g_pos_only
      assign r_q_n = 1'b0;
    end
  endgenerate

  // Flipping either half flips the visible level; no data ever muxes on clk.
  assign q = r_q_p ^ r_q_n;

endmodule

// File: rtl/full_adder_1bit.sv
// Toggle-encoded 1-bit full adder: one pulse window per clock event.
module full_adder_1bit
  import full_adder_1bit_pkg::*;
#(
  parameter bit DUAL_EDGE = 1'b1
) (
  input  logic cin,
  input  logic a,
  input  logic b,
  input  logic clk,
  output logic sum,
  output logic cout,
  input  logic rst
);

  fa_pulse_t w_in;
  fa_pulse_t w_ref;
  fa_pulse_t w_p;
  fa_pulse_t r_ref_p;
  fa_pulse_t r_ref_n;
  logic      w_s;
  logic      w_c;

  assign w_in = fa_pulse_t'({a, b, cin});

  // Each edge stores level^other_half so that r_ref_p^r_ref_n always equals
  // the input level seen at the most recent event, whichever edge it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ref_p <= '0;
    else     r_ref_p <= fa_pulse_t'(w_in ^ r_ref_n);
  end

  generate
    if (DUAL_EDGE) begin : g_ref_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst) r_ref_n <= '0;
        else     r_ref_n <= fa_pulse_t'(w_in ^ r_ref_p);
      end
    end else begin : g_ref_pos_only
      assign r_ref_n = '0;
    end
  endgenerate

  assign w_ref = fa_pulse_t'(r_ref_p ^ r_ref_n);
  assign w_p   = fa_pulse_t'(w_in ^ w_ref);
  assign w_s   = fa_par3(w_p);
  assign w_c   = fa_maj3(w_p);

  dual_edge_toggle #(.DUAL_EDGE(DUAL_EDGE)) u_sum (
    .clk (clk),
    .rst (rst),
    .t   (w_s),
    .q   (sum)
  );

  dual_edge_toggle #(.DUAL_EDGE(DUAL_EDGE)) u_cout (
    .clk (clk),
    .rst (rst),
    .t   (w_c),
    .q   (cout)
  );

endmodule

// File: tb/tb_full_adder_1bit.sv
// Scoreboard bench: dual-edge and rising-only adders driven by the same pulse lines.
module tb_full_adder_1bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sum0, cout0;

  full_adder_1bit_if ifc ();

  full_adder_1bit #(.DUAL_EDGE(1'b1)) dut1 (
    .cin (ifc.cin), .a (ifc.a), .b (ifc.b), .clk (clk),
    .sum (ifc.sum), .cout (ifc.cout), .rst (rst)
  );

  full_adder_1bit #(.DUAL_EDGE(1'b0)) dut0 (
    .cin (ifc.cin), .a (ifc.a), .b (ifc.b), .clk (clk),
    .sum (sum0), .cout (cout0), .rst (rst)
  );

  always #20 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] q1[$];
  logic [1:0] q0[$];
  logic [1:0] lvl1, lvl0;
  logic [1:0] hold0 = 2'b00;
  int         c1[3];
  int         c0[3];

  task automatic check(input string nm, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: sum,cout=%b expected %b at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: parity of each input's toggle count is its pulse; count the pulses.
  function automatic logic [1:0] advance(input logic [1:0] lvl, input int ca, input int cb, input int cc);
    int n;
    n = (ca % 2) + (cb % 2) + (cc % 2);
    return {lvl[1] ^ (n % 2 == 1), lvl[0] ^ (n >= 2)};
  endfunction

  always @(posedge rst) hold0 = 2'b00;

  // Monitor: every clock event, compare against the oldest expected value.
  initial begin
    forever begin
      @(clk);
      #1;
      if (rst) check("dual_in_reset", {ifc.sum, ifc.cout}, 2'b00);
      else if (q1.size() > 0) check("dual_event", {ifc.sum, ifc.cout}, q1.pop_front());
      if (clk) begin
        if (q0.size() > 0) hold0 = q0.pop_front();
        check("single_posedge", {sum0, cout0}, hold0);
      end else begin
        check("single_negedge_hold", {sum0, cout0}, hold0);
      end
    end
  end

  task automatic window(input int na, input int nb, input int nc, input bit rmid);
    bit to_pos;
    @(clk);
    #2;
    to_pos = (clk == 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i < na) begin ifc.a   = ~ifc.a;   #1; end
      if (i < nb) begin ifc.b   = ~ifc.b;   #1; end
      if (i < nc) begin ifc.cin = ~ifc.cin; #1; end
    end
    c1[0] += na; c1[1] += nb; c1[2] += nc;
    c0[0] += na; c0[1] += nb; c0[2] += nc;
    if (rmid) begin
      #1 rst = 1'b1;
      #1 begin ifc.a = 1'b0; ifc.b = 1'b0; ifc.cin = 1'b0; end
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin c1[i] = 0; c0[i] = 0; end
      lvl1 = 2'b00;
      lvl0 = 2'b00;
    end
    lvl1 = advance(lvl1, c1[0], c1[1], c1[2]);
    for (int i = 0; i < 3; i++) c1[i] = 0;
    q1.push_back(lvl1);
    if (to_pos) begin
      lvl0 = advance(lvl0, c0[0], c0[1], c0[2]);
      for (int i = 0; i < 3; i++) c0[i] = 0;
      q0.push_back(lvl0);
    end
  endtask

  initial begin
    ifc.a = 1'b0; ifc.b = 1'b0; ifc.cin = 1'b0;
    lvl1 = 2'b00; lvl0 = 2'b00;
    for (int i = 0; i < 3; i++) begin c1[i] = 0; c0[i] = 0; end
    #1;
    check("reset_state_dual", {ifc.sum, ifc.cout}, 2'b00);
    check("reset_state_single", {sum0, cout0}, 2'b00);
    repeat (4) @(clk);
    #3 rst = 1'b0;
    q1.push_back(2'b00);
    if (clk == 1'b0) q0.push_back(2'b00);

    window(1, 0, 0, 0); window(0, 1, 0, 0); window(0, 0, 1, 0);
    window(1, 1, 0, 0); window(1, 0, 1, 0); window(0, 1, 1, 0);
    window(1, 1, 1, 0);
    window(2, 0, 0, 0);
    window(1, 0, 0, 1);
    window(0, 1, 0, 0);
    window(0, 0, 0, 0); window(0, 0, 0, 0);
    window(1, 0, 0, 0);
    window(0, 0, 0, 0);
    repeat (300)
      window($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 39) == 0);

    @(clk);
    #2;
    check("queues_drained", {q1.size() == 0, q0.size() == 0}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/full_adder_1bit.md
FULL_ADDER_1BIT -- requirements
Module: full_adder_1bit

Interface
REQ-001 Parameter DUAL_EDGE, default 1: 1 = every clk transition is a clock event; 0 = only clk rising edges are clock events.
REQ-002 clk  input  1  clock; the clock event is defined by DUAL_EDGE.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cin  input  1  carry-in pulse line, toggle-encoded.
REQ-005 a  input  1  operand A pulse line, toggle-encoded.
REQ-006 b  input  1  operand B pulse line, toggle-encoded.
REQ-007 sum  output  1  sum pulse line, toggle-encoded.
REQ-008 cout  output  1  carry-out pulse line, toggle-encoded.
REQ-009 Positional port order SHALL be cin, a, b, clk, sum, cout, rst.
REQ-010 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-011 Encoding: each level transition on a pulse line SHALL represent one pulse; the absolute level carries no meaning.
REQ-012 The interval between consecutive clock events SHALL be one window.
REQ-013 Input pulse pending flags SHALL be computed as pX = X XOR X_ref, where X_ref is the level of input X captured at the previous clock event.
REQ-014 An even number of toggles of one input within a window SHALL count as no pulse.
REQ-015 At each clock event, the block SHALL compute s = pa^pb^pc and c = majority(pa,pb,pc).
REQ-016 At each clock event, sum SHALL toggle iff s=1, and cout SHALL toggle iff c=1.
REQ-017 At each clock event, every X_ref SHALL be reloaded with the current input level.
REQ-018 Latency: outputs SHALL change on the clock event that closes the window; zero further cycles.
REQ-019 A window with no input pulses SHALL leave sum and cout unchanged.
REQ-020 An input toggle coincident with a clock event SHALL be counted in the window that event closes.
REQ-021 Pulse count 3 (a, b and cin) SHALL toggle both sum and cout.
REQ-022 With DUAL_EDGE=1, state SHALL be held in paired posedge/negedge registers.
REQ-023 With DUAL_EDGE=1, each output level SHALL be the XOR of its posedge and negedge toggle registers.
REQ-024 With DUAL_EDGE=1, each X_ref SHALL be taken from the register updated by the most recent edge.
REQ-025 The outputs SHALL be glitch-free registered values, with no combinational input-to-output path.

Reset
REQ-026 While rst=1, sum and cout SHALL read 0, all toggle registers SHALL be 0, and all X_ref SHALL be 0.
REQ-027 Inputs SHALL be held at 0 while rst=1; the first window after release SHALL count toggles relative to 0.
REQ-028 Reset asserted mid-window SHALL discard pending pulses, with no output toggle.
REQ-029 Clock events while rst=1 SHALL have no effect.

Structure
REQ-030 No shared package is required.
REQ-031 The dual-edge toggle register SHALL be one sub-module, dual_edge_toggle (inputs clk, rst, t; output q), instantiated for sum and cout.
REQ-032 Pending-flag logic and adder logic SHALL live in full_adder_1bit.

Verification
REQ-033 Inputs at 0, rst pulse, first clk event with no inputs -> sum=0, cout=0.
REQ-034 Exhaustive sequence, one clk event per step, toggling a; b; cin; a+b; a+cin; b+cin; a+b+cin -> per step: sum toggles, sum toggles, sum toggles, cout toggles, cout toggles, cout toggles, both toggle; final sum=0, cout=0 after rst-zero start.
REQ-035 Toggle a twice within one window, then clk event -> no output change.
REQ-036 a toggled, then rst asserted before clk event, then rst released and clk event -> sum=0, cout=0.
REQ-037 DUAL_EDGE=0: a toggled, then clk falling edge -> no change; next rising edge -> sum toggles.
REQ-038 Two idle clk events after activity -> sum and cout hold their levels.
